// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg
//   Constants and helpers shared by the pipelined adder and its chunk adder.
//   A stage record is {valid, carry, rotated operand A / partial sum, shifted
//   operand B}. The record widths depend on the WIDTH parameter, so the record
//   lives in the top as parallel arrays. This package supplies the sizing
//   helpers for those arrays.
package pipelined_adder_pkg;

    localparam int MAX_STAGES = 8;

    // Width of one chunk. It is guarded so that a bad STAGES value reaches
    // the parameter check instead of failing on a divide by zero.
    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? width / stages : 1;
    endfunction

    // Number of operand-B registers. The last stage holds no B bits; the
    // result is at least 1 so that the array stays legal when STAGES=1.
    function automatic int b_regs(input int stages);
        return (stages > 1) ? stages - 1 : 1;
    endfunction

    function automatic bit params_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= MAX_STAGES) && (width > 0) &&
               (width % stages == 0);
    endfunction

endpackage

// File: rtl/add_chunk.sv
// add_chunk
//   Combinational CW-bit adder slice with carry in and carry out.
//   Ports: a, b (CW bits), carry_in -> sum (CW bits), carry_out.
module add_chunk
    import pipelined_adder_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          carry_in,
    output logic [CW-1:0] sum,
    output logic          carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, carry_in};

endmodule

// File: rtl/pipelined_adder_vr.sv
// pipelined_adder_vr
//   A WIDTH-bit adder split into STAGES chunks. The adder uses a valid/ready
//   handshake on both sides. Chunk k is added between register k-1 and
//   register k. Chunk 0 is added from the input ports. The last register
//   drives the outputs directly.
//   Ports: clk, rst (async, active-high);
//          a, b, in_valid -> in_ready;
//          c, carry_out, out_valid <- out_ready.
module pipelined_adder_vr
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry_out,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = chunk_width(WIDTH, STAGES);
    localparam int NB = b_regs(STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_param_err
        $error("pipelined_adder_vr: STAGES must be 1..%0d and divide WIDTH", MAX_STAGES);
    end

    // Register k holds the record produced by chunk k.
    logic [STAGES-1:0] vld_d, vld_q;
    logic [STAGES-1:0] cy_d, cy_q;
    logic [WIDTH-1:0]  ra_d [STAGES];
    logic [WIDTH-1:0]  ra_q [STAGES];
    logic [WIDTH-1:0]  rb_d [NB];
    logic [WIDTH-1:0]  rb_q [NB];

    // Chunk k reads its inputs from these sources.
    logic [STAGES-1:0] v_src, cy_src, cout_k, adv, ld;
    logic [WIDTH-1:0]  a_src [STAGES];
    logic [WIDTH-1:0]  b_src [STAGES];
    logic [WIDTH-1:0]  ra_nx [STAGES];
    logic [WIDTH-1:0]  rb_nx [NB];
    logic [CW-1:0]     sum_k [STAGES];

    assign v_src = STAGES'({vld_q, in_valid});

    // A register may take new data when it is empty or when it is draining
    // this cycle. The chain is evaluated from the output back to the input,
    // so a bubble anywhere lets everything upstream of it move.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = !vld_q[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = !vld_q[k] || adv[k+1];
        end
    end

    assign ld = adv & v_src;

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        if (k == 0) begin : g_src
            assign a_src[k]  = a;
            assign b_src[k]  = b;
            assign cy_src[k] = 1'b0;
        end else begin : g_src
            assign a_src[k]  = ra_q[k-1];
            assign b_src[k]  = rb_q[k-1];
            assign cy_src[k] = cy_q[k-1];
        end

        // The current chunk of each operand is always in the low CW bits.
        add_chunk #(.CW(CW)) u_add (
            .a        (a_src[k][CW-1:0]),
            .b        (b_src[k][CW-1:0]),
            .carry_in (cy_src[k]),
            .sum      (sum_k[k]),
            .carry_out(cout_k[k])
        );

        // A is rotated right by one chunk at each stage, and the new sum
        // chunk enters at the top. After STAGES rotations the word is the
        // full sum in natural bit order.
        if (CW == WIDTH) begin : g_rot
            assign ra_nx[k] = sum_k[k];
        end else begin : g_rot
            assign ra_nx[k] = {sum_k[k], a_src[k][WIDTH-1:CW]};
        end

        // B only needs to shift. No stage after the last chunk reads it.
        if (k < STAGES - 1) begin : g_bsh
            assign rb_nx[k] = b_src[k] >> CW;
        end
    end

    if (STAGES == 1) begin : g_no_b
        assign rb_nx[0] = '0;
    end

    always_comb begin
        vld_d = vld_q;
        cy_d  = cy_q;
        for (int k = 0; k < STAGES; k++) begin
            vld_d[k] = adv[k] ? v_src[k] : vld_q[k];
            cy_d[k]  = ld[k] ? cout_k[k] : cy_q[k];
            ra_d[k]  = ld[k] ? ra_nx[k] : ra_q[k];
        end
        for (int k = 0; k < NB; k++) begin
            rb_d[k] = (k < STAGES - 1 && ld[k]) ? rb_nx[k] : rb_q[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    // Data registers have no reset. Their contents are ignored while the
    // valid bit of the same stage is low.
    always_ff @(posedge clk) begin
        cy_q <= cy_d;
        for (int k = 0; k < STAGES; k++) ra_q[k] <= ra_d[k];
        for (int k = 0; k < NB; k++)     rb_q[k] <= rb_d[k];
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_q[STAGES-1];
    assign c         = ra_q[STAGES-1];
    assign carry_out = cy_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder_vr.sv
// tb_pipelined_adder_vr
//   Directed bench for pipelined_adder_vr with WIDTH=32 and STAGES=4.
//   Inputs change on the falling edge. Outputs are sampled 1 ns later,
//   before the next rising edge.
module tb_pipelined_adder_vr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        in_ready, out_valid, carry_out;
    logic [31:0] c;
    int          total = 0;
    int          bad = 0;

    pipelined_adder_vr #(.WIDTH(32), .STAGES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .c        (c),
        .carry_out(carry_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic step(input logic v, input logic [31:0] aa, input logic [31:0] bb,
                        input logic ordy);
        @(negedge clk);
        in_valid  = v;
        a         = aa;
        b         = bb;
        out_ready = ordy;
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h100 + i, 32'h200, 1'b0);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_in_ready[%0d] got=%b exp=1", i, in_ready); end
        end
        step(1'b0, 32'h0, 32'h0, 1'b0);
        total++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
            begin bad++; $display("FAIL full_flags got=%b%b exp=10", out_valid, in_ready); end
        // Assert reset in the middle of the cycle and check before the next edge.
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL async_rst got=%b%b exp=01", out_valid, in_ready); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; a = 32'd5; b = 32'd7; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL first_accept got=%b exp=1", in_ready); end
        for (int cyc = 1; cyc <= 4; cyc++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1);
            total++; if (out_valid !== (cyc == 4))
                begin bad++; $display("FAIL post_rst_valid[%0d] got=%b exp=%b", cyc, out_valid, cyc == 4); end
        end
        total++; if (c !== 32'd12 || carry_out !== 1'b0)
            begin bad++; $display("FAIL post_rst_sum got=%h/%b exp=0000000c/0", c, carry_out); end
        step(1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_carry();
        step(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL carry_accept got=%b exp=1", in_ready); end
        for (int cyc = 1; cyc <= 4; cyc++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1);
            total++; if (out_valid !== (cyc == 4))
                begin bad++; $display("FAIL carry_latency[%0d] got=%b exp=%b", cyc, out_valid, cyc == 4); end
        end
        total++; if (c !== 32'h0 || carry_out !== 1'b1)
            begin bad++; $display("FAIL carry_sum got=%h/%b exp=00000000/1", c, carry_out); end
        step(1'b0, 32'h0, 32'h0, 1'b1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL carry_dup got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc < 8) step(1'b1, 32'(cyc), 32'h8000_0000 + cyc, 1'b1);
            else         step(1'b0, 32'h0, 32'h0, 1'b1);
            if (cyc < 8) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=1", cyc, in_ready); end
            end
            total++; if (out_valid !== (cyc >= 4 && cyc < 12))
                begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", cyc, out_valid, cyc >= 4 && cyc < 12); end
            if (cyc >= 4 && cyc < 12) begin
                total++; if (c !== 32'h8000_0000 + 2 * (cyc - 4) || carry_out !== 1'b0)
                    begin bad++; $display("FAIL b2b_sum[%0d] got=%h/%b exp=%h/0", cyc, c, carry_out, 32'h8000_0000 + 2 * (cyc - 4)); end
            end
        end
    endtask

    task automatic test_stall_fill();
        // Items n: a=0x1000+n, b=0x0FFF_F000, so sum=0x1000_0000+n.
        for (int s = 0; s < 6; s++) begin
            step(1'b1, 32'h1000 + (s < 4 ? s : 4), 32'h0FFF_F000, 1'b0);
            total++; if (in_ready !== (s < 4))
                begin bad++; $display("FAIL stall_ready[%0d] got=%b exp=%b", s, in_ready, s < 4); end
        end
        // Full pipeline with out_ready=1 must still accept item 4.
        for (int d = 0; d < 6; d++) begin
            if (d == 0) step(1'b1, 32'h1004, 32'h0FFF_F000, 1'b1);
            else        step(1'b0, 32'h0, 32'h0, 1'b1);
            if (d == 0) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_accept got=%b exp=1", in_ready); end
            end
            total++; if (out_valid !== (d < 5))
                begin bad++; $display("FAIL drain_valid[%0d] got=%b exp=%b", d, out_valid, d < 5); end
            if (d < 5) begin
                total++; if (c !== 32'h1000_0000 + d)
                    begin bad++; $display("FAIL drain_sum[%0d] got=%h exp=%h", d, c, 32'h1000_0000 + d); end
            end
        end
    endtask

    task automatic test_collapse();
        for (int s = 0; s < 13; s++) begin
            if (s == 0)      step(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0);
            else if (s == 2) step(1'b1, 32'hDEAD_BEEF, 32'h2152_4111, 1'b0);
            else             step(1'b0, 32'h0, 32'h0, s >= 10);
            if (s == 2) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bubble_ready got=%b exp=1", in_ready); end
            end
            if (s >= 4 && s <= 10) begin
                total++; if (out_valid !== 1'b1 || c !== 32'h2345_6789)
                    begin bad++; $display("FAIL hold_first[%0d] got=%b/%h exp=1/23456789", s, out_valid, c); end
            end
            if (s == 11) begin
                total++; if (out_valid !== 1'b1 || c !== 32'h0 || carry_out !== 1'b1)
                    begin bad++; $display("FAIL collapse_second got=%b/%h/%b exp=1/00000000/1", out_valid, c, carry_out); end
            end
            if (s == 12) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL collapse_dup got=%b exp=0", out_valid); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int s = 0; s < 3; s++) step(1'b1, 32'h50 + s, 32'h1, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL mid_rst got=%b%b exp=01", out_valid, in_ready); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 8; s++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flushed[%0d] got=%b exp=0", s, out_valid); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_carry();
        test_back_to_back();
        test_stall_fill();
        test_collapse();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_adder_vr.md
PIPELINED_ADDER_VR -- requirements
Module: pipelined_adder_vr

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4, meaning pipeline register stages (1..8); WIDTH SHALL be divisible by STAGES.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-005 SHALL have port a  input  WIDTH  operand A.
REQ-006 SHALL have port b  input  WIDTH  operand B.
REQ-007 SHALL have port in_valid  input  1  operands valid.
REQ-008 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-009 SHALL have port c  output  WIDTH  sum a+b modulo 2^WIDTH.
REQ-010 SHALL have port carry_out  output  1  carry out of bit WIDTH-1.
REQ-011 SHALL have port out_valid  output  1  c/carry_out valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.

Function
REQ-013 SHALL split the add into STAGES chunks of CW=WIDTH/STAGES bits; chunk k (LSB first) SHALL be computed between register stage k and k+1, chunk 0 on the input ports.
REQ-014 Each stage register SHALL hold: valid bit, completed low sum bits, remaining unprocessed A/B bits, inter-chunk carry.
REQ-015 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-016 Stage i SHALL advance (capture from stage i-1) when stage i is empty or stage i is advancing into stage i+1 (output stage: out_ready); advance SHALL be computed combinationally from the tail.
REQ-017 in_ready SHALL equal the advance condition of stage 1 (bubbles collapse; an empty slot anywhere lets upstream move).
REQ-018 Latency SHALL be exactly STAGES cycles from accept to out_valid when unstalled; throughput one result per cycle.
REQ-019 c, carry_out, out_valid SHALL be driven directly from the last stage register (no extra output flop).
REQ-020 Data fields of a stage SHALL load only when that stage advances with valid input; otherwise hold (no data change while stalled).
REQ-021 A stage advancing with invalid upstream SHALL clear its valid bit.
REQ-022 Results SHALL emerge in accept order; none lost, duplicated or reordered under any out_ready pattern.
REQ-023 in_valid while in_ready=0 SHALL have no effect; upstream holds operands.
REQ-024 Simultaneous accept and emit on a full pipeline SHALL be permitted (in_ready=1 when out_ready=1).

Reset
REQ-025 rst high SHALL clear all stage valid bits immediately (asynchronously): out_valid=0, in_ready=1.
REQ-026 Data/carry registers SHALL NOT be reset; c and carry_out are don't-care while out_valid=0.
REQ-027 Reset mid-operation SHALL discard all in-flight operands; no result from them appears after release.
REQ-028 First accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-029 A shared package pipelined_adder_pkg SHALL hold MAX_STAGES=8 and the stage-record typedef helper constants.
REQ-030 Chunk addition SHALL be a combinational sub-module add_chunk (CW-bit a, b, carry_in -> sum, carry_out), instantiated STAGES times via generate.
REQ-031 Parameter checks (STAGES range, divisibility) SHALL fail elaboration when violated.

Verification (WIDTH=32, STAGES=4)
REQ-032 rst pulse mid-cycle -> out_valid=0 and in_ready=1 before next clock edge.
REQ-033 a=0xFFFF_FFFF, b=0x1 accepted cycle 0, out_ready=1 -> cycle 4 out_valid=1, c=0x0, carry_out=1.
REQ-034 8 back-to-back pairs (a=i, b=0x8000_0000+i), out_ready=1 -> 8 consecutive results from cycle 4, c=0x8000_0000+2i.
REQ-035 Stream with out_ready=0 -> exactly 4 accepts then in_ready=0; out_ready=1 -> all 4 results in order, one per cycle, no duplicates.
REQ-036 One item, out_ready=0 for 10 cycles, second item sent cycle 2 -> second collapses behind first; both emerge on consecutive cycles after release.
REQ-037 3 items in flight, rst asserted 1 cycle -> out_valid stays 0 for 8 cycles after release with in_valid=0.
